// File: rtl/led_mux_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module : led_mux_display_ctrl
// Brief  : Multiplexed 7-segment LED driver feeding two HC164 shift registers
//          (digit select + segments) with PWM dimming via blank frames.
// Rev    : 1.0  initial release
// ============================================================================
module led_mux_display_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV_RATE     = 62000,
  parameter int DIV_WIDTH    = 16,
  parameter int SHIFT_DIV    = 1,
  parameter bit COMMON_ANODE = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic [2:0]              i_brightness,
  input  logic [8*NUM_DIGITS-1:0] i_display,
  input  logic [NUM_DIGITS-1:0]   i_blank_mask,
  output logic                    o_shifter_a_ds,
  output logic                    o_shifter_a_cp,
  output logic                    o_shifter_a_mr_n,
  output logic                    o_shifter_b_ds,
  output logic                    o_shifter_b_cp,
  output logic                    o_shifter_b_mr_n,
  output logic                    o_busy,
  output logic                    o_frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int HP_W  = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
  localparam logic [IDX_W-1:0]     C_LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_WIDTH-1:0] C_CNT_MAX  = DIV_WIDTH'(DIV_RATE - 1);
  localparam logic [HP_W-1:0]      C_HP_MAX   = HP_W'(SHIFT_DIV - 1);
  localparam logic [DIV_WIDTH+2:0] C_RATE     = (DIV_WIDTH + 3)'(DIV_RATE);

  typedef enum logic [2:0] {
    INIT        = 3'd0,
    WAIT_SLOT   = 3'd1,
    SHIFT_DIGIT = 3'd2,
    WAIT_DIM    = 3'd3,
    SHIFT_BLANK = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [DIV_WIDTH-1:0]    cnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic [IDX_W-1:0]        dig_q;
  logic [8*NUM_DIGITS-1:0] snap_disp_q;
  logic [NUM_DIGITS-1:0]   snap_mask_q;
  logic [2:0]              bright_q;
  logic [7:0]              sr_a_q, sr_a_d;
  logic [7:0]              sr_b_q, sr_b_d;
  logic [HP_W-1:0]         hp_q, hp_d;
  logic [3:0]              half_q, half_d;
  logic                    ds_a_q, ds_b_q, cp_q, mr_n_q, busy_q, frame_done_q;

  logic                    w_boundary;
  logic [DIV_WIDTH-1:0]    w_cnt_next;
  logic                    w_new_frame;
  logic [8*NUM_DIGITS-1:0] w_disp;
  logic [NUM_DIGITS-1:0]   w_mask;
  logic [7:0]              w_onehot;
  logic [7:0]              w_byte;
  logic                    w_mask_bit;
  logic                    w_blank;
  logic [DIV_WIDTH+2:0]    w_thr;
  logic                    w_thr_hit;
  logic                    w_hp_end;
  logic                    w_shift_end;
  logic                    w_shift_d;

  assign w_boundary  = (cnt_q == C_CNT_MAX);
  assign w_cnt_next  = w_boundary ? '0 : cnt_q + 1'b1;
  assign w_new_frame = w_boundary && (idx_q == C_LAST_IDX);
  // The snapshot is taken on the same edge that loads the first digit, so
  // bypass the register for that load.
  assign w_disp      = w_new_frame ? i_display    : snap_disp_q;
  assign w_mask      = w_new_frame ? i_blank_mask : snap_mask_q;
  assign w_blank     = ~i_enable | w_mask_bit;

  always_comb begin
    w_onehot   = 8'h00;
    w_byte     = 8'h00;
    w_mask_bit = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        w_onehot[8-NUM_DIGITS+k] = 1'b1;
        w_byte                   = w_disp[8*k +: 8];
        w_mask_bit               = w_mask[k];
      end
    end
  end

  // The next count is compared so the blank shift begins exactly at the threshold.
  assign w_thr       = (({{DIV_WIDTH{1'b0}}, bright_q} + 1'b1) * C_RATE) >> 3;
  assign w_thr_hit   = ({3'b000, w_cnt_next} >= w_thr);
  assign w_hp_end    = (hp_q == C_HP_MAX);
  assign w_shift_end = w_hp_end && (half_q == 4'd15);
  assign w_shift_d   = (state_d == SHIFT_DIGIT) || (state_d == SHIFT_BLANK);

  always_comb begin
    state_d = state_q;
    sr_a_d  = sr_a_q;
    sr_b_d  = sr_b_q;
    hp_d    = hp_q;
    half_d  = half_q;
    case (state_q)
      INIT: state_d = WAIT_SLOT;
      WAIT_SLOT: begin
        if (w_boundary) begin
          state_d = SHIFT_DIGIT;
          sr_a_d  = w_blank ? 8'h00 : w_onehot;
          sr_b_d  = w_blank ? 8'h00 : w_byte;
          hp_d    = '0;
          half_d  = 4'd0;
        end
      end
      SHIFT_DIGIT, SHIFT_BLANK: begin
        hp_d = hp_q + 1'b1;
        if (w_hp_end) begin
          hp_d   = '0;
          half_d = half_q + 4'd1;
          if (half_q[0]) begin
            sr_a_d = {sr_a_q[6:0], 1'b0};
            sr_b_d = {sr_b_q[6:0], 1'b0};
          end
        end
        if (w_shift_end) begin
          if ((state_q == SHIFT_BLANK) || (bright_q == 3'd7)) begin
            state_d = WAIT_SLOT;
          end else if (w_thr_hit) begin
            state_d = SHIFT_BLANK;
            sr_a_d  = 8'h00;
            sr_b_d  = 8'h00;
          end else begin
            state_d = WAIT_DIM;
          end
        end
      end
      WAIT_DIM: begin
        if (w_thr_hit) begin
          state_d = SHIFT_BLANK;
          sr_a_d  = 8'h00;
          sr_b_d  = 8'h00;
          hp_d    = '0;
          half_d  = 4'd0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= INIT;
      cnt_q        <= '0;
      idx_q        <= C_LAST_IDX;
      dig_q        <= C_LAST_IDX;
      snap_disp_q  <= '0;
      snap_mask_q  <= '0;
      bright_q     <= 3'd0;
      sr_a_q       <= 8'h00;
      sr_b_q       <= 8'h00;
      hp_q         <= '0;
      half_q       <= 4'd0;
      ds_a_q       <= COMMON_ANODE;
      ds_b_q       <= COMMON_ANODE;
      cp_q         <= 1'b0;
      mr_n_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= w_cnt_next;
      sr_a_q       <= sr_a_d;
      sr_b_q       <= sr_b_d;
      hp_q         <= hp_d;
      half_q       <= half_d;
      ds_a_q       <= (w_shift_d & sr_a_d[7]) ^ COMMON_ANODE;
      ds_b_q       <= (w_shift_d & sr_b_d[7]) ^ COMMON_ANODE;
      cp_q         <= w_shift_d & half_d[0];
      mr_n_q       <= 1'b1;
      busy_q       <= w_shift_d;
      frame_done_q <= (state_q == SHIFT_DIGIT) && w_shift_end && (dig_q == '0);
      if (w_boundary) begin
        idx_q    <= (idx_q == '0) ? C_LAST_IDX : idx_q - 1'b1;
        bright_q <= i_brightness;
        if (state_q == WAIT_SLOT) begin
          dig_q <= idx_q;
        end
      end
      if (w_new_frame) begin
        snap_disp_q <= i_display;
        snap_mask_q <= i_blank_mask;
      end
    end
  end

  assign o_shifter_a_ds   = ds_a_q;
  assign o_shifter_a_cp   = cp_q;
  assign o_shifter_a_mr_n = mr_n_q;
  assign o_shifter_b_ds   = ds_b_q;
  assign o_shifter_b_cp   = cp_q;
  assign o_shifter_b_mr_n = mr_n_q;
  assign o_busy           = busy_q;
  assign o_frame_done     = frame_done_q;

endmodule
`default_nettype wire
